// File: rtl/hex_display_scanner_pkg.sv
// rtl/hex_display_scanner_pkg.sv - shared constants, state encoding and leading-zero helper
package hex_display_scanner_pkg;

  localparam int unsigned NUM_DIGITS           = 4;
  localparam int unsigned NIBBLE_W             = 4;
  localparam int unsigned DEFAULT_DIV          = 50000;
  localparam int unsigned DEFAULT_BLANK_CYCLES = 2;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Digit 0 is never suppressed; digit i is suppressed when digits i..3 are all zero.
  function automatic logic lz_blank(input logic [NUM_DIGITS*NIBBLE_W-1:0] val,
                                    input logic [1:0] idx,
                                    input logic en);
    logic zero;
    zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && val[i*NIBBLE_W +: NIBBLE_W] != '0) begin
        zero = 1'b0;
      end
    end
    return en && (idx != 2'd0) && zero;
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// rtl/hex_display_scanner_if.sv - load handshake and scan outputs of the hex display scanner
interface hex_display_scanner_if;
  import hex_display_scanner_pkg::*;

  logic                             load;
  logic [NUM_DIGITS*NIBBLE_W-1:0]   value;
  logic                             ready;
  logic                             lz_blank_en;
  logic                             x3;
  logic                             x2;
  logic                             x1;
  logic                             x0;
  logic [NUM_DIGITS-1:0]            digit_en_n;
  logic                             blank;

  modport master (
    output load, value, lz_blank_en,
    input  ready, x3, x2, x1, x0, digit_en_n, blank
  );

  modport slave (
    input  load, value, lz_blank_en,
    output ready, x3, x2, x1, x0, digit_en_n, blank
  );

endinterface

// File: rtl/hex_display_scanner_scan_timer.sv
// rtl/hex_display_scanner_scan_timer.sv - phase counter with selectable length and terminal-count pulse
module hex_display_scanner_scan_timer #(
  parameter int unsigned SHOW_LEN  = 4,
  parameter int unsigned BLANK_LEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_show,
  output logic tc
);

  localparam int unsigned MAX_LEN = (SHOW_LEN > BLANK_LEN) ? SHOW_LEN : BLANK_LEN;
  localparam int          CW      = $clog2(MAX_LEN);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_LEN - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LEN - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (sel_show ? SHOW_LAST : BLANK_LAST));

  // Wrapping on tc clears the count in the same cycle the phase changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - four-digit hex scan with dead-time, leading-zero blanking and frame-aligned load
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int unsigned DIV          = DEFAULT_DIV,
  parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input logic                  Clock,
  input logic                  Resetn,
  hex_display_scanner_if.slave bus
);

  localparam int unsigned VW = NUM_DIGITS * NIBBLE_W;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  ready_q, ready_d;
  logic [NIBBLE_W-1:0]   nib_q, nib_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [VW-1:0]         src;
  logic                  tc;

  hex_display_scanner_scan_timer #(
    .SHOW_LEN  (DIV),
    .BLANK_LEN (BLANK_CYCLES)
  ) u_timer (
    .clk      (Clock),
    .rst_n    (Resetn),
    .sel_show (state_q == ST_SHOW),
    .tc       (tc)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_BLANK;
      idx_q     <= 2'd0;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      nib_q     <= '0;
      blank_q   <= 1'b0;
      en_q      <= '1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      nib_q     <= nib_d;
      blank_q   <= blank_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    nib_d     = nib_q;
    blank_d   = blank_q;
    en_d      = en_q;
    src       = disp_q;

    if (bus.load && ready_q) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end

    case (state_q)
      ST_BLANK: begin
        en_d = '1;
        if (tc) begin
          state_d = ST_SHOW;
          en_d    = blank_q ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        end
      end
      ST_SHOW: begin
        if (tc) begin
          state_d = ST_BLANK;
          en_d    = '1;
          idx_d   = idx_q + 2'd1;
          // Frame boundary: the new digit 0 already comes from the committed value.
          if (idx_q == 2'd3 && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
            src       = shadow_q;
          end
          nib_d   = src[{idx_d, 2'b00} +: NIBBLE_W];
          blank_d = lz_blank(src, idx_d, bus.lz_blank_en);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign bus.ready      = ready_q;
  assign bus.x3         = nib_q[3];
  assign bus.x2         = nib_q[2];
  assign bus.x1         = nib_q[1];
  assign bus.x0         = nib_q[0];
  assign bus.digit_en_n = en_q;
  assign bus.blank      = blank_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - scoreboard bench for hex_display_scanner
module tb_hex_display_scanner;

  localparam int DV = 4;
  localparam int BL = 1;

  typedef struct packed {
    logic [1:0] digit;
    logic [3:0] x;
    logic       blank;
  } slot_t;

  logic  Clock = 1'b0;
  logic  Resetn;
  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    t        = 0;
  logic  mon_go   = 1'b0;

  always #5 Clock = ~Clock;

  hex_display_scanner_if bus();

  hex_display_scanner #(
    .DIV          (DV),
    .BLANK_CYCLES (BL)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge Clock);
    t += n;
  endtask

  task automatic push_slot(input logic [1:0] d, input logic [3:0] x, input logic b);
    slot_t s;
    s.digit = d;
    s.x     = x;
    s.blank = b;
    exp_q.push_back(s);
  endtask

  task automatic push_frame(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3,
                            input logic [3:0] bmask);
    push_slot(2'd0, n0, bmask[0]);
    push_slot(2'd1, n1, bmask[1]);
    push_slot(2'd2, n2, bmask[2]);
    push_slot(2'd3, n3, bmask[3]);
  endtask

  // Monitor: one scoreboard entry per digit slot, checked on every cycle of the slot.
  initial begin
    slot_t       e;
    logic [3:0]  exp_en;
    int          slot_n;
    slot_n = 0;
    forever begin
      wait (mon_go);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < BL + DV; c++) begin
          exp_en = (c < BL || e.blank) ? 4'b1111 : ~(4'b0001 << e.digit);
          n_checks++;
          if ({bus.digit_en_n, bus.x3, bus.x2, bus.x1, bus.x0, bus.blank} !== {exp_en, e.x, e.blank}) begin
            n_fail++;
            $display("FAIL slot%0d cyc%0d en_n/x/blank: got %b/%h/%b expected %b/%h/%b",
                     slot_n, c, bus.digit_en_n, {bus.x3, bus.x2, bus.x1, bus.x0}, bus.blank,
                     exp_en, e.x, e.blank);
          end
          @(negedge Clock);
        end
        slot_n++;
      end
      mon_go = 1'b0;
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    Resetn          = 1'b0;
    bus.load        = 1'b0;
    bus.value       = 16'h0000;
    bus.lz_blank_en = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset en_n", 32'(bus.digit_en_n), 32'hF);
    check("reset x", 32'({bus.x3, bus.x2, bus.x1, bus.x0}), 32'h0);
    check("reset blank", 32'(bus.blank), 32'h0);
    check("reset ready", 32'(bus.ready), 32'h1);

    // Plain scan, load 0x1A3F mid-frame, ignored second load.
    Resetn = 1'b1;
    t = 0;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    push_frame(4'hF, 4'h3, 4'hA, 4'h1, 4'b0000);
    push_frame(4'hF, 4'h3, 4'hA, 4'h1, 4'b0000);
    mon_go = 1'b1;
    adv(7);
    bus.value = 16'h1A3F;
    bus.load  = 1'b1;
    adv(1);
    check("ready after load", 32'(bus.ready), 32'h0);
    bus.value = 16'h5555;
    adv(1);
    bus.load = 1'b0;
    check("ready while pending", 32'(bus.ready), 32'h0);
    adv(10);
    check("ready before commit", 32'(bus.ready), 32'h0);
    adv(1);
    check("ready after commit", 32'(bus.ready), 32'h1);
    adv(40);

    // Leading-zero suppression: 0x0040 then 0x0000.
    bus.lz_blank_en = 1'b1;
    push_frame(4'hF, 4'h3, 4'hA, 4'h1, 4'b0000);
    push_frame(4'h0, 4'h4, 4'h0, 4'h0, 4'b1100);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b1110);
    mon_go = 1'b1;
    adv(2);
    bus.value = 16'h0040;
    bus.load  = 1'b1;
    adv(1);
    bus.load = 1'b0;
    check("ready after load 0040", 32'(bus.ready), 32'h0);
    adv(17);
    check("ready after commit 0040", 32'(bus.ready), 32'h1);
    adv(2);
    bus.value = 16'h0000;
    bus.load  = 1'b1;
    adv(1);
    bus.load = 1'b0;
    adv(37);

    // Reset mid-SHOW of digit 2 with 0x1234 pending.
    bus.lz_blank_en = 1'b0;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    mon_go = 1'b1;
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    adv(1);
    bus.load = 1'b0;
    check("ready pending 1234", 32'(bus.ready), 32'h0);
    adv(11);
    check("en_n digit2 before reset", 32'(bus.digit_en_n), 32'hB);
    Resetn = 1'b0;
    #1;
    check("async reset en_n", 32'(bus.digit_en_n), 32'hF);
    check("async reset ready", 32'(bus.ready), 32'h1);
    check("async reset x", 32'({bus.x3, bus.x2, bus.x1, bus.x0}), 32'h0);
    check("async reset blank", 32'(bus.blank), 32'h0);
    adv(2);
    Resetn = 1'b1;
    t = 0;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    mon_go = 1'b1;
    check("ready after reset release", 32'(bus.ready), 32'h1);
    adv(40);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
